// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone B4 pipelined slave bus between N masters.
// Optional watchdog release is built when WB_ARBITER_RR_TIMEOUT_EN is defined.
module wb_arbiter_rr #(
    parameter int N       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [4*N-1:0]  m_sel_i,
    input  logic [16*N-1:0] m_adr_i,
    input  logic [32*N-1:0] m_dat_i,
    output logic [31:0]     m_dat_o,
    output logic [N-1:0]    m_stall_o,
    output logic [N-1:0]    m_ack_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [3:0]      wb_sel_o,
    output logic [15:0]     wb_adr_o,
    output logic [31:0]     wb_dat_o,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
`ifdef WB_ARBITER_RR_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic [N-1:0]    grant_o
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    // Handshake: a master owns the bus from the grant until it drops cyc; only the
    // owner sees wb_stall_i/wb_ack_i, every other master sees stall=1, ack=0.
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   sel_idx;
    logic [GW-1:0]   cand_idx;
    logic            busy;
    logic            found;
    logic            timeout_hit;
    int              cand;

    assign busy = (state_q == BUSY);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= GW'(N - 1);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
        end
    end

    // Rotating search starts just after the last served master, so the one
    // releasing the bus is considered last.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        case (state_q)
            IDLE: begin
                for (int i = 1; i <= N; i++) begin
                    cand = int'(last_q) + i;
                    if (cand >= N) cand = cand - N;
                    cand_idx = GW'(cand);
                    if (!found && m_cyc_i[cand_idx]) begin
                        found   = 1'b1;
                        g_d     = cand_idx;
                        last_d  = cand_idx;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!m_cyc_i[g_q] || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_idx = busy ? g_q : '0;

    always_comb begin
        wb_cyc_o  = busy & m_cyc_i[g_q];
        wb_stb_o  = busy & m_cyc_i[g_q] & m_stb_i[g_q];
        wb_we_o   = m_we_i[sel_idx];
        wb_sel_o  = m_sel_i[4*int'(sel_idx) +: 4];
        wb_adr_o  = m_adr_i[16*int'(sel_idx) +: 16];
        wb_dat_o  = m_dat_i[32*int'(sel_idx) +: 32];
        m_stall_o = '1;
        m_ack_o   = '0;
        grant_o   = '0;
        if (busy) begin
            m_stall_o[g_q] = wb_stall_i;
            m_ack_o[g_q]   = wb_ack_i | timeout_hit;
            grant_o[g_q]   = 1'b1;
        end
        m_dat_o = timeout_hit ? 32'hFFFF_FFFF : wb_dat_i;
    end

`ifdef WB_ARBITER_RR_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] wd_q;
    logic          to_q;

    // Fires on the TIMEOUT-th consecutive ack-less clock of an active cycle.
    assign timeout_hit = busy && wb_cyc_o && !wb_ack_i && (wd_q == CW'(TIMEOUT - 1));
    assign timeout_o   = to_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (!busy || wb_ack_i || timeout_hit) wd_q <= '0;
            else if (wb_cyc_o)                    wd_q <= wd_q + 1'b1;
            if (timeout_hit) to_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (N=2): grant, rotation, ack routing, stalled burst, async reset.
module tb_wb_arbiter_rr;

    localparam int N = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_ni;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [4*N-1:0]  m_sel_i;
    logic [16*N-1:0] m_adr_i;
    logic [32*N-1:0] m_dat_i;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_stall_o, m_ack_o, grant_o;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]      wb_sel_o;
    logic [15:0]     wb_adr_o;
    logic [31:0]     wb_dat_o, wb_dat_i;
    logic            wb_stall_i, wb_ack_i;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
    logic            timeout_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int n_ack  = 0;

    logic [6:0] stall_v, stb_v, ack_v;

    wb_arbiter_rr #(.N(N)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .m_cyc_i    (m_cyc_i),
        .m_stb_i    (m_stb_i),
        .m_we_i     (m_we_i),
        .m_sel_i    (m_sel_i),
        .m_adr_i    (m_adr_i),
        .m_dat_i    (m_dat_i),
        .m_dat_o    (m_dat_o),
        .m_stall_o  (m_stall_o),
        .m_ack_o    (m_ack_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
`ifdef WB_ARBITER_RR_TIMEOUT_EN
        .timeout_o  (timeout_o),
`endif
        .grant_o    (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_rst_ni  = 1'b0;
        m_cyc_i    = '0;
        m_stb_i    = '0;
        m_we_i     = '0;
        m_sel_i    = '0;
        m_adr_i    = '0;
        m_dat_i    = '0;
        wb_dat_i   = '0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        stall_v    = 7'b0000011;
        stb_v      = 7'b0111111;
        ack_v      = 7'b1111000;

        // Reset state
        #2;
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_cyc",   32'(wb_cyc_o), 32'h0);
        check("rst_stb",   32'(wb_stb_o), 32'h0);
        check("rst_stall", 32'(m_stall_o), 32'h3);
        check("rst_ack",   32'(m_ack_o), 32'h0);
        tick();
        wb_rst_ni = 1'b1;
        tick();

        // Single master 0 request
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        m_adr_i[15:0] = 16'h0010;
        #1;
        check("t1_pre_grant", 32'(grant_o), 32'h0);
        check("t1_pre_cyc",   32'(wb_cyc_o), 32'h0);
        tick();
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_cyc",   32'(wb_cyc_o), 32'h1);
        check("t1_stb",   32'(wb_stb_o), 32'h1);
        check("t1_adr",   32'(wb_adr_o), 32'h0010);
        check("t1_stall", 32'(m_stall_o), 32'h2);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick();
        check("t1_release", 32'(grant_o), 32'h0);

        // Fresh reset, then simultaneous requests: master 0 first
        wb_rst_ni = 1'b0;
        #2;
        wb_rst_ni = 1'b1;
        tick();
        m_cyc_i = 2'b11;
        tick();
        check("t2_first", 32'(grant_o), 32'h1);
        m_cyc_i = 2'b10;
        tick();
        check("t2_idle_grant", 32'(grant_o), 32'h0);
        check("t2_idle_stall", 32'(m_stall_o), 32'h3);
        wb_ack_i = 1'b1;
        #1;
        check("t2_idle_ack_dropped", 32'(m_ack_o), 32'h0);
        wb_ack_i = 1'b0;
        tick();
        check("t2_second", 32'(grant_o), 32'h2);
        check("t2_cyc",    32'(wb_cyc_o), 32'h1);

        // Ack routed to master 1 only
        m_stb_i = 2'b10;
        m_adr_i[31:16] = 16'h0020;
        m_dat_i[63:32] = 32'h1234_5678;
        wb_dat_i = 32'hCAFE_F00D;
        wb_ack_i = 1'b1;
        #1;
        check("t3_ack",   32'(m_ack_o), 32'h2);
        check("t3_dat",   m_dat_o, 32'hCAFE_F00D);
        check("t3_adr",   32'(wb_adr_o), 32'h0020);
        check("t3_wdat",  wb_dat_o, 32'h1234_5678);
        wb_ack_i = 1'b0;
        m_stb_i  = 2'b00;
        m_cyc_i  = 2'b00;
        tick();
        check("t3_release", 32'(grant_o), 32'h0);

        // Stalled burst of 4 on master 0 with master 1 waiting
        m_cyc_i = 2'b11;
        tick();
        check("t4_grant", 32'(grant_o), 32'h1);
        for (int c = 0; c < 7; c++) begin
            m_stb_i    = {1'b1, stb_v[c]};
            wb_stall_i = stall_v[c];
            wb_ack_i   = ack_v[c];
            #1;
            check($sformatf("t4_stall_c%0d", c), 32'(m_stall_o), 32'({1'b1, stall_v[c]}));
            check($sformatf("t4_ack_c%0d", c),   32'(m_ack_o),   32'({1'b0, ack_v[c]}));
            check($sformatf("t4_stb_c%0d", c),   32'(wb_stb_o),  32'(stb_v[c]));
            n_ack += int'(m_ack_o[0]);
            tick();
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        check("t4_ack_count", 32'(n_ack), 32'd4);
        m_cyc_i = 2'b10;
        m_stb_i = 2'b00;
        tick();
        check("t4_idle", 32'(grant_o), 32'h0);
        tick();
        check("t4_rotate", 32'(grant_o), 32'h2);
        m_cyc_i = 2'b00;
        tick();

        // Reset mid-write while master 0 owns the bus; master 1 also waiting
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        m_we_i  = 2'b01;
        tick();
        check("t5_grant", 32'(grant_o), 32'h1);
        check("t5_we",    32'(wb_we_o), 32'h1);
        m_cyc_i = 2'b11;
        #2;
        wb_rst_ni = 1'b0;
        #1;
        check("t5_async_cyc",   32'(wb_cyc_o), 32'h0);
        check("t5_async_stb",   32'(wb_stb_o), 32'h0);
        check("t5_async_grant", 32'(grant_o), 32'h0);
        #1;
        wb_rst_ni = 1'b1;
        tick();
        check("t5_restart", 32'(grant_o), 32'h1);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        m_we_i  = 2'b00;
        tick();
        check("t5_end", 32'(grant_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
